conv_sequencer: RTL

Parametrised successor to the fixed-geometry CNN controller. It sequences one complete convolution pass over NK kernels, in five steps: filter load, image-buffer load, a per-window/per-kernel clear-accumulate-write loop, buffer shift, and done. Sizes are parameters, and the kernel loop is a native counter rather than an external kernel counter. Two handshakes are added: a memory read grant (`mem_gnt`) and output backpressure (`out_ready`). The block sits between the input memory, the filter/image buffers, the MAC datapath and the output memory.

---
 rtl/conv_sequencer.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/conv_sequencer.sv
// conv_sequencer
// Control sequencer for one full convolution pass over NK kernels:
// filter load, image-buffer load, then for every output window and kernel a
// clear / accumulate / write loop, with a one-cycle image shift between
// windows. Memory reads are paced by mem_gnt and result writes by out_ready.
// All outputs are decoded from registered state and counters; the only
// input-to-output paths are the two buffer write strobes, which qualify the
// current load state with mem_gnt.

module conv_sequencer #(
  parameter  int NK   = 4,   // kernels per pass (>= 1)
  parameter  int FR   = 4,   // filter words per kernel
  parameter  int IR   = 16,  // image rows loaded before compute
  parameter  int TAPS = 16,  // MAC cycles per window
  parameter  int NWIN = 8,   // output windows per pass
  parameter  int AW   = 10,  // memory address width
  localparam int RMAX = (FR > IR) ? FR : IR,
  localparam int KW   = (NK   > 1) ? $clog2(NK)   : 1,
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1,
  localparam int TW   = (TAPS > 1) ? $clog2(TAPS) : 1,
  localparam int WW   = (NWIN > 1) ? $clog2(NWIN) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          mem_gnt,
  input  logic          out_ready,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  output logic          fbuf_we,
  output logic          img_we,
  output logic [KW-1:0] buf_kernel,
  output logic [RW-1:0] buf_row,
  output logic          acc_clr,
  output logic          mac_en,
  output logic [TW-1:0] mac_tap,
  output logic          shift,
  output logic          out_valid,
  output logic [WW-1:0] out_win,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LDF,
    S_LDI,
    S_CLR,
    S_MAC,
    S_WR,
    S_SLIDE,
    S_DONE
  } state_t;

  // Terminal counts, sized to the counters they are compared against.
  localparam logic [KW-1:0] K_LAST  = KW'(NK - 1);
  localparam logic [RW-1:0] R_FLAST = RW'(FR - 1);
  localparam logic [RW-1:0] R_ILAST = RW'(IR - 1);
  localparam logic [TW-1:0] T_LAST  = TW'(TAPS - 1);
  localparam logic [WW-1:0] W_LAST  = WW'(NWIN - 1);

  state_t        state;
  logic [KW-1:0] k;
  logic [RW-1:0] r;
  logic [TW-1:0] t;
  logic [WW-1:0] w;
  logic [AW-1:0] addr;

  // Sequencer state and loop counters; every counter advances only on the
  // event that consumes it (grant, tap, handshake, slide).
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, so it lives inside the clocked branch and
    // is only seen on a rising edge; a mid-pass reset simply drops to IDLE.
    if (rst) begin
      // NOTE: non-blocking assignments throughout, so every branch reads the
      // pre-edge counter values regardless of statement order.
      state <= S_IDLE;
      k     <= '0;
      r     <= '0;
      t     <= '0;
      w     <= '0;
      addr  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            k     <= '0;
            r     <= '0;
            t     <= '0;
            w     <= '0;
            addr  <= '0;
            state <= S_LDF;
          end
        end

        S_LDF: begin
          if (mem_gnt) begin
            addr <= addr + AW'(1);
            if (r == R_FLAST) begin
              r <= '0;
              if (k == K_LAST) begin
                k     <= '0;
                state <= S_LDI;
              end else begin
                k <= k + KW'(1);
              end
            end else begin
              r <= r + RW'(1);
            end
          end
        end

        S_LDI: begin
          if (mem_gnt) begin
            addr <= addr + AW'(1);
            if (r == R_ILAST) begin
              r     <= '0;
              state <= S_CLR;
            end else begin
              r <= r + RW'(1);
            end
          end
        end

        S_CLR: state <= S_MAC;

        S_MAC: begin
          if (t == T_LAST) begin
            t     <= '0;
            state <= S_WR;
          end else begin
            t <= t + TW'(1);
          end
        end

        S_WR: begin
          if (out_ready) begin
            if (k != K_LAST) begin
              k     <= k + KW'(1);
              state <= S_CLR;
            end else if (w != W_LAST) begin
              k     <= '0;
              state <= S_SLIDE;
            end else begin
              state <= S_DONE;
            end
          end
        end

        S_SLIDE: begin
          w     <= w + WW'(1);
          state <= S_CLR;
        end

        // Indices return to zero so IDLE always presents a clean state;
        // addr is deliberately kept until the next start.
        S_DONE: begin
          k     <= '0;
          r     <= '0;
          t     <= '0;
          w     <= '0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  // Moore output decode: each index is driven only in the states that use it.
  always_comb begin
    // NOTE: every output gets a default before the case, so no state can
    // leave one unassigned and infer a latch.
    mem_rd     = 1'b0;
    fbuf_we    = 1'b0;
    img_we     = 1'b0;
    buf_kernel = '0;
    buf_row    = '0;
    acc_clr    = 1'b0;
    mac_en     = 1'b0;
    mac_tap    = '0;
    shift      = 1'b0;
    out_valid  = 1'b0;
    out_win    = '0;
    done       = 1'b0;
    busy       = (state != S_IDLE);
    mem_addr   = addr;

    case (state)
      S_LDF: begin
        mem_rd     = 1'b1;
        fbuf_we    = mem_gnt;
        buf_kernel = k;
        buf_row    = r;
      end
      S_LDI: begin
        mem_rd  = 1'b1;
        img_we  = mem_gnt;
        buf_row = r;
      end
      S_CLR: acc_clr = 1'b1;
      S_MAC: begin
        mac_en     = 1'b1;
        mac_tap    = t;
        buf_kernel = k;
      end
      S_WR: begin
        out_valid  = 1'b1;
        buf_kernel = k;
        out_win    = w;
      end
      S_SLIDE: shift = 1'b1;
      S_DONE:  done  = 1'b1;
      default: ;
    endcase
  end

endmodule
